mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 104 ++++++++++
 tb/tb_mem_io_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte bus to 128 KB RAM, UART RX/TX FIFO and stop flag; cycle counter
// and its coherent snapshot exist only when MEM_IO_CYCLE_COUNTER_EN is defined.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_done
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(TX_DEPTH);
    localparam logic [PW:0] FULL_AT = (PW+1)'(TX_DEPTH - 2);

    logic [7:0]    r_ram [0:(1<<RAM_ADDR_WIDTH)-1];
    logic [7:0]    r_fifo [0:TX_DEPTH-1];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_tx_cnt;
    logic [7:0]    r_din;
    logic          r_rx_pop, r_full, r_done;
    logic          w_io, w_rd, w_push, w_pop, w_acc, w_unused;
    logic [15:0]   w_off;
    logic [7:0]    w_push_data, w_io_data, w_cnt_data;
    logic [PW:0]   w_tx_cnt_nxt;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_a;

    assign w_unused     = &{1'b0, cpu_a[31:18]};
    assign w_io         = cpu_a[17:16] == 2'b11;
    assign w_off        = cpu_a[15:0];
    assign w_ram_a      = cpu_a[RAM_ADDR_WIDTH-1:0];
    assign w_rd         = !cpu_wr;
    assign w_pop        = tx_valid && tx_ready;
    assign w_push       = cpu_wr && w_io && ((w_off == 16'h0000 && cpu_dout != 8'h00) || w_off == 16'h0004);
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_acc        = w_push && (r_tx_cnt != DEPTH_C || w_pop);
    assign w_push_data  = w_off == 16'h0004 ? 8'h00 : cpu_dout;
    assign w_tx_cnt_nxt = r_tx_cnt + (PW+1)'(w_acc) - (PW+1)'(w_pop);

`ifdef MEM_IO_CYCLE_COUNTER_EN
    logic [31:0] r_cyc, r_snap;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cyc  <= 32'd0;
            r_snap <= 32'd0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_rd && w_io && w_off == 16'h0004) r_snap <= r_cyc;
        end
    end
    // Byte 0 comes straight from the live counter; bytes 1-3 from the snapshot it took
    assign w_cnt_data = w_off == 16'h0004 ? r_cyc[7:0] :
                        w_off[15:2] == 14'h0001 ? r_snap[{w_off[1:0], 3'b000} +: 8] : 8'h00;
`else
    assign w_cnt_data = 8'h00;
`endif

    assign w_io_data = w_off == 16'h0000 ? (rx_valid ? rx_data : 8'h00) : w_cnt_data;

    always_ff @(posedge clk_in) begin
        if (cpu_wr && !w_io) r_ram[w_ram_a] <= cpu_dout;
    end

    always_ff @(posedge clk_in) begin
        if (w_acc) r_fifo[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_din    <= 8'h00;
            r_rx_pop <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_tx_cnt <= '0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_din    <= w_io ? w_io_data : r_ram[w_ram_a];
            r_rx_pop <= w_rd && w_io && w_off == 16'h0000 && rx_valid;
            if (w_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_tx_cnt <= w_tx_cnt_nxt;
            r_full   <= w_tx_cnt_nxt >= FULL_AT;
            if (cpu_wr && w_io && w_off == 16'h0004) r_done <= 1'b1;
        end
    end

    assign cpu_din        = r_din;
    assign rx_pop         = r_rx_pop;
    assign io_buffer_full = r_full;
    assign tx_valid       = r_tx_cnt != '0;
    assign tx_data        = r_fifo[r_rd_ptr];
    assign program_done   = r_done;
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: randomized scenarios for mem_io_responder checked against a
// queue/array model of RAM, RX port and TX FIFO.
module tb_mem_io_responder;
    localparam int TX_DEPTH = 8;

    logic        clk_in = 1'b0, rst_in = 1'b1;
    logic [31:0] cpu_a = 32'h0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dout = 8'h0, rx_data = 8'h0;
    logic        rx_valid = 1'b0, tx_ready = 1'b0;
    logic [7:0]  cpu_din, tx_data;
    logic        io_buffer_full, rx_pop, tx_valid, program_done;

    int checks = 0, passed = 0;
    logic [7:0] mem [int];
    logic [7:0] txq [$];

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .io_buffer_full(io_buffer_full), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_pop(rx_pop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .program_done(program_done)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic op(input logic wr, input logic [31:0] a, input logic [7:0] d);
        cpu_wr = wr; cpu_a = a; cpu_dout = d;
        @(posedge clk_in); @(negedge clk_in);
        cpu_wr = 1'b0; cpu_a = 32'h0; cpu_dout = 8'h0;
    endtask

    task automatic test_reset;
        @(negedge clk_in);
        checks++; if (cpu_din !== 8'h00) $display("FAIL rst_din: got %h want 00", cpu_din); else passed++;
        checks++; if (rx_pop !== 1'b0) $display("FAIL rst_rx_pop: got %b want 0", rx_pop); else passed++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL rst_tx_valid: got %b want 0", tx_valid); else passed++;
        checks++; if (io_buffer_full !== 1'b0) $display("FAIL rst_full: got %b want 0", io_buffer_full); else passed++;
        checks++; if (program_done !== 1'b0) $display("FAIL rst_done: got %b want 0", program_done); else passed++;
        rst_in = 1'b0;
    endtask

    task automatic test_ram;
        op(1'b1, 32'h10, 8'h5A); mem[32'h10] = 8'h5A;
        op(1'b0, 32'h10, 8'h00);
        checks++; if (cpu_din !== 8'h5A) $display("FAIL ram_fwd: got %h want 5a", cpu_din); else passed++;
        for (int i = 0; i < 60; i++) begin
            int ad;
            logic [31:0] a;
            logic [7:0] d;
            ad = ($urandom_range(0, 31) * 4099) % 131072;
            a = {14'($urandom), 1'b0, 17'(ad)};
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1 || !mem.exists(ad)) begin
                op(1'b1, a, d); mem[ad] = d;
            end else begin
                op(1'b0, a, 8'h00);
                checks++; if (cpu_din !== mem[ad]) $display("FAIL ram_rand @%h: got %h want %h", ad, cpu_din, mem[ad]); else passed++;
            end
        end
    endtask

    task automatic test_rx;
        rx_valid = 1'b1; rx_data = 8'h41;
        op(1'b0, 32'hABC30000, 8'h00);
        checks++; if (cpu_din !== 8'h41) $display("FAIL rx_data: got %h want 41", cpu_din); else passed++;
        checks++; if (rx_pop !== 1'b1) $display("FAIL rx_pop_pulse: got %b want 1", rx_pop); else passed++;
        op(1'b0, 32'h0, 8'h00);
        checks++; if (rx_pop !== 1'b0) $display("FAIL rx_pop_end: got %b want 0", rx_pop); else passed++;
        rx_valid = 1'b0;
        op(1'b0, 32'h30000, 8'h00);
        checks++; if (cpu_din !== 8'h00) $display("FAIL rx_empty: got %h want 00", cpu_din); else passed++;
        checks++; if (rx_pop !== 1'b0) $display("FAIL rx_nopop: got %b want 0", rx_pop); else passed++;
        for (int i = 0; i < 8; i++) begin
            logic rv;
            logic [7:0] rd;
            rv = 1'($urandom_range(0, 1)); rd = 8'($urandom);
            rx_valid = rv; rx_data = rd;
            op(1'b0, 32'h30000, 8'h00);
            checks++; if (cpu_din !== (rv ? rd : 8'h00)) $display("FAIL rx_rand: got %h want %h", cpu_din, rv ? rd : 8'h00); else passed++;
            checks++; if (rx_pop !== rv) $display("FAIL rx_rand_pop: got %b want %b", rx_pop, rv); else passed++;
        end
        rx_valid = 1'b0;
    endtask

    task automatic drain;
        tx_ready = 1'b1;
        for (int k = 0; k < 3 * TX_DEPTH && txq.size() > 0; k++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== txq[0]) $display("FAIL tx_order: got %b/%h want 1/%h", tx_valid, tx_data, txq[0]); else passed++;
            @(posedge clk_in); @(negedge clk_in);
            void'(txq.pop_front());
        end
        tx_ready = 1'b0;
        checks++; if (txq.size() != 0 || tx_valid !== 1'b0) $display("FAIL tx_drain: left %0d valid %b want 0/0", txq.size(), tx_valid); else passed++;
    endtask

    task automatic test_tx_fill;
        tx_ready = 1'b0;
        for (int i = 0; i < TX_DEPTH + 1; i++) begin
            logic [7:0] d;
            d = 8'(8'h31 + i);
            op(1'b1, 32'h30000, d);
            if (txq.size() < TX_DEPTH) txq.push_back(d);
            checks++; if (io_buffer_full !== (i >= TX_DEPTH - 3)) $display("FAIL tx_full_%0d: got %b want %b", i, io_buffer_full, i >= TX_DEPTH - 3); else passed++;
        end
        checks++; if (tx_data !== 8'h31) $display("FAIL tx_head: got %h want 31", tx_data); else passed++;
        drain();
        checks++; if (io_buffer_full !== 1'b0) $display("FAIL tx_full_clear: got %b want 0", io_buffer_full); else passed++;
    endtask

    task automatic test_full_pushpop;
        for (int i = 0; i < TX_DEPTH; i++) begin
            op(1'b1, 32'h30000, 8'(8'h61 + i)); txq.push_back(8'(8'h61 + i));
        end
        tx_ready = 1'b1;
        op(1'b1, 32'h30000, 8'h69);
        void'(txq.pop_front()); txq.push_back(8'h69);
        drain();
    endtask

    task automatic test_tx_random;
        for (int i = 0; i < 120; i++) begin
            logic rdy, wr, pop, acc;
            logic [7:0] d;
            rdy = 1'($urandom_range(0, 1));
            wr = $urandom_range(0, 2) != 0;
            d = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            pop = rdy && txq.size() > 0;
            acc = wr && d != 8'h00 && (txq.size() < TX_DEPTH || pop);
            if (pop) void'(txq.pop_front());
            if (acc) txq.push_back(d);
            tx_ready = rdy; cpu_wr = wr; cpu_a = 32'h30000; cpu_dout = d;
            @(posedge clk_in); @(negedge clk_in);
            checks++; if (tx_valid !== (txq.size() > 0)) $display("FAIL txr_valid %0d: got %b want %b", i, tx_valid, txq.size() > 0); else passed++;
            if (txq.size() > 0) begin
                checks++; if (tx_data !== txq[0]) $display("FAIL txr_data %0d: got %h want %h", i, tx_data, txq[0]); else passed++;
            end
            checks++; if (io_buffer_full !== (TX_DEPTH - txq.size() <= 2)) $display("FAIL txr_full %0d: got %b want %b", i, io_buffer_full, TX_DEPTH - txq.size() <= 2); else passed++;
        end
        cpu_wr = 1'b0; cpu_a = 32'h0;
        drain();
    endtask

    task automatic test_program_done;
        tx_ready = 1'b0;
        op(1'b1, 32'h30000, 8'h00);
        checks++; if (tx_valid !== 1'b0) $display("FAIL zero_push: got %b want 0", tx_valid); else passed++;
        op(1'b1, 32'h30008, 8'h55);
        checks++; if (tx_valid !== 1'b0) $display("FAIL other_io_wr: got %b want 0", tx_valid); else passed++;
        op(1'b1, 32'h300, 8'h77);
        op(1'b0, 32'h300, 8'h00);
        op(1'b0, 32'h30008, 8'h00);
        checks++; if (cpu_din !== 8'h00) $display("FAIL other_io_rd: got %h want 00", cpu_din); else passed++;
        checks++; if (program_done !== 1'b0) $display("FAIL done_early: got %b want 0", program_done); else passed++;
        op(1'b1, 32'h30004, 8'h00);
        checks++; if (program_done !== 1'b1) $display("FAIL done_set: got %b want 1", program_done); else passed++;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) $display("FAIL done_push: got %b/%h want 1/00", tx_valid, tx_data); else passed++;
        txq.push_back(8'h00);
        op(1'b1, 32'h200, 8'hC3);
        op(1'b0, 32'h200, 8'h00);
        checks++; if (cpu_din !== 8'hC3) $display("FAIL ram_after_done: got %h want c3", cpu_din); else passed++;
        drain();
        checks++; if (program_done !== 1'b1) $display("FAIL done_sticky: got %b want 1", program_done); else passed++;
    endtask

    task automatic test_counter;
        logic [7:0] b [4];
        @(negedge clk_in); rst_in = 1'b1;
        @(negedge clk_in); rst_in = 1'b0;
        repeat (100) op(1'b0, 32'h0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            op(1'b0, 32'h30004 + 32'(k), 8'h00); b[k] = cpu_din;
        end
`ifdef MEM_IO_CYCLE_COUNTER_EN
        checks++; if ({b[3], b[2], b[1], b[0]} !== 32'd100) $display("FAIL cnt_100: got %0d want 100", {b[3], b[2], b[1], b[0]}); else passed++;
        repeat (300) op(1'b0, 32'h0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            op(1'b0, 32'h30004 + 32'(k), 8'h00); b[k] = cpu_din;
        end
        checks++; if ({b[3], b[2], b[1], b[0]} !== 32'd404) $display("FAIL cnt_404: got %0d want 404", {b[3], b[2], b[1], b[0]}); else passed++;
`else
        for (int k = 0; k < 4; k++) begin
            checks++; if (b[k] !== 8'h00) $display("FAIL cnt_absent_%0d: got %h want 00", k, b[k]); else passed++;
        end
`endif
    endtask

    task automatic test_reset_mid;
        tx_ready = 1'b0;
        op(1'b1, 32'h123, 8'hA7);
        op(1'b1, 32'h30000, 8'h11);
        op(1'b1, 32'h30000, 8'h22);
        op(1'b1, 32'h30004, 8'h00);
        op(1'b0, 32'h123, 8'h00);
        checks++; if (tx_valid !== 1'b1 || program_done !== 1'b1 || cpu_din !== 8'hA7) $display("FAIL pre_rst: got %b/%b/%h want 1/1/a7", tx_valid, program_done, cpu_din); else passed++;
        #2 rst_in = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", tx_valid); else passed++;
        checks++; if (program_done !== 1'b0) $display("FAIL mid_rst_done: got %b want 0", program_done); else passed++;
        checks++; if (cpu_din !== 8'h00) $display("FAIL mid_rst_din: got %h want 00", cpu_din); else passed++;
        @(negedge clk_in); rst_in = 1'b0;
        op(1'b0, 32'h123, 8'h00);
        checks++; if (cpu_din !== 8'hA7) $display("FAIL ram_kept: got %h want a7", cpu_din); else passed++;
        checks++; if (tx_valid !== 1'b0) $display("FAIL tx_flushed: got %b want 0", tx_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_rx();
        test_tx_fill();
        test_full_pushpop();
        test_tx_random();
        test_program_done();
        test_counter();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
